// File: rtl/arashi_pkg.sv
// Shared types, defaults and sizing helpers for the arashi read buffer.
package arashi_pkg;

    localparam int DEF_DATA_WIDTH       = 32;
    localparam int DEF_THREAD_NUM_WIDTH = 2;
    localparam int DEF_MEM_WIDTH        = 4;

    typedef logic [DEF_THREAD_NUM_WIDTH-1:0] thread_id_t;

    function automatic int pow2(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/arashi_rr_arbiter.sv
// Round-robin arbiter; the search starts one past the last granted thread.
module arashi_rr_arbiter
    import arashi_pkg::*;
#(
    parameter int THREAD_NUM_WIDTH = DEF_THREAD_NUM_WIDTH
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [pow2(THREAD_NUM_WIDTH)-1:0]   req,
    input  logic                                enable,
    output logic [pow2(THREAD_NUM_WIDTH)-1:0]   grant,
    output logic [THREAD_NUM_WIDTH-1:0]         grant_id,
    output logic                                grant_vld
);

    localparam int THREAD_NUM = pow2(THREAD_NUM_WIDTH);

    logic [THREAD_NUM_WIDTH-1:0] last_k;
    logic [THREAD_NUM_WIDTH-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_k <= THREAD_NUM_WIDTH'(THREAD_NUM - 1);
        end else if (grant_vld) begin
            last_k <= grant_id;
        end
    end

    // Offset THREAD_NUM wraps back to last_k itself, making it the lowest priority.
    always_comb begin
        grant     = '0;
        grant_id  = last_k;
        grant_vld = 1'b0;
        idx       = last_k;
        for (int i = 1; i <= THREAD_NUM; i++) begin
            idx = last_k + THREAD_NUM_WIDTH'(i);
            if (enable && !grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arashi_rd_buf.sv
// Circular buffer between the cache write stream and per-thread read slices.
module arashi_rd_buf
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int THREAD_NUM_WIDTH = DEF_THREAD_NUM_WIDTH,
    parameter int MEM_WIDTH        = DEF_MEM_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         wr_valid,
    output logic                                         wr_ready,
    input  logic [DATA_WIDTH-1:0]                        wr_data,
    input  logic [pow2(THREAD_NUM_WIDTH)-1:0]            rd_req,
    output logic [pow2(THREAD_NUM_WIDTH)-1:0]            rd_grant,
    output logic [pow2(THREAD_NUM_WIDTH)-1:0]            rd_valid,
    output logic [DATA_WIDTH*pow2(THREAD_NUM_WIDTH)-1:0] data_out,
    output logic [MEM_WIDTH:0]                           count,
    output logic                                         full,
    output logic                                         empty
);

    localparam int THREAD_NUM = pow2(THREAD_NUM_WIDTH);
    localparam int DEPTH      = pow2(MEM_WIDTH);

    logic [DATA_WIDTH-1:0]       mem [DEPTH];
    logic [MEM_WIDTH-1:0]        wptr;
    logic [MEM_WIDTH-1:0]        rptr;
    logic [THREAD_NUM_WIDTH-1:0] grant_id;
    logic                        grant_vld;
    logic                        wr_fire;

    assign full     = (count == (MEM_WIDTH+1)'(DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign wr_fire  = wr_valid && wr_ready;

    arashi_rr_arbiter #(
        .THREAD_NUM_WIDTH(THREAD_NUM_WIDTH)
    ) u_arb (
        .clk      (clk),
        .rstn     (rstn),
        .req      (rd_req),
        .enable   (!empty),
        .grant    (rd_grant),
        .grant_id (grant_id),
        .grant_vld(grant_vld)
    );

    // No reset on the array so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_fire) begin
                wptr <= wptr + MEM_WIDTH'(1);
            end
            if (grant_vld) begin
                rptr <= rptr + MEM_WIDTH'(1);
            end
            case ({wr_fire, grant_vld})
                2'b10:   count <= count + (MEM_WIDTH+1)'(1);
                2'b01:   count <= count - (MEM_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_valid <= '0;
            data_out <= '0;
        end else begin
            rd_valid <= rd_grant;
            if (grant_vld) begin
                data_out[grant_id*DATA_WIDTH +: DATA_WIDTH] <= mem[rptr];
            end
        end
    end

endmodule
